// File: rtl/cif_chreq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cif_chreq_pkg
// Brief    : Shared types and default sizes for the CIF channel requester.
// Revision : 1.0 - initial release
// ============================================================================
package cif_chreq_pkg;

    localparam int CH_NUM_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int LEN_W_DEF      = 8;
    localparam int ADDR_W_DEF     = 32;
    localparam int BEAT_BYTES_DEF = 64;

    localparam int CH_W  = $clog2(CH_NUM_DEF);
    localparam int PTR_W = $clog2(FIFO_DEPTH_DEF);

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [LEN_W_DEF-1:0]  len;
    } cmd_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cif_chreq_if.sv
`default_nettype none
// ============================================================================
// Module   : cif_chreq_if
// Brief    : Command, arbitration and transmit signals of the CIF requester.
// Revision : 1.0 - initial release
// ============================================================================
interface cif_chreq_if #(
    parameter int CH_NUM = 8,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 32
);
    localparam int c_ch_w = $clog2(CH_NUM);

    logic [CH_NUM-1:0]        cmd_valid;
    logic [CH_NUM-1:0]        cmd_ready;
    logic [CH_NUM*LEN_W-1:0]  cmd_len;
    logic [CH_NUM*ADDR_W-1:0] cmd_addr;
    logic [CH_NUM-1:0]        req;
    logic [CH_NUM-1:0]        gnt;
    logic                     arbenb;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [c_ch_w-1:0]        tx_ch;
    logic [ADDR_W-1:0]        tx_addr;
    logic                     tx_last;
    logic [CH_NUM-1:0]        done;
    logic                     err;

    modport master (
        input  cmd_valid, cmd_len, cmd_addr, gnt, tx_ready,
        output cmd_ready, req, arbenb, tx_valid, tx_ch, tx_addr, tx_last, done, err
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_addr, gnt, tx_ready,
        input  cmd_ready, req, arbenb, tx_valid, tx_ch, tx_addr, tx_last, done, err
    );

endinterface
`default_nettype wire

// File: rtl/cif_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cif_cmd_fifo
// Brief    : Single-clock command FIFO with occupancy count, no bypass.
// Revision : 1.0 - initial release
// ============================================================================
module cif_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int WIDTH = 40
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic      [PTR_W:0]   o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cif_chreq.sv
`default_nettype none
// ============================================================================
// Module   : cif_chreq
// Brief    : CIF channel requester - per-channel command queues, grant
//            handling and burst playback onto the shared transmit bus.
// Revision : 1.0 - initial release
// ============================================================================
module cif_chreq
    import cif_chreq_pkg::*;
#(
    parameter int CH_NUM     = CH_NUM_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BEAT_BYTES = BEAT_BYTES_DEF
) (
    input  wire logic   user_clk,
    input  wire logic   reset_n,
    cif_chreq_if.master bus
);

    localparam int c_ch_w   = $clog2(CH_NUM);
    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_data_w = ADDR_W + LEN_W;

    logic [CH_NUM-1:0]   w_full;
    logic [CH_NUM-1:0]   w_empty;
    logic [CH_NUM-1:0]   w_nonempty;
    logic [CH_NUM-1:0]   w_push;
    logic [CH_NUM-1:0]   w_pop;
    logic [c_data_w-1:0] w_dout  [CH_NUM];
    logic [c_ptr_w:0]    w_count [CH_NUM];

    logic [c_ch_w-1:0]   w_gnt_idx;
    logic                w_grant_ok;
    logic                w_gnt_bad;
    logic [c_data_w-1:0] w_head;
    logic                w_hs;
    logic [CH_NUM-1:0]   w_done;

    state_t              r_state;
    logic [c_ch_w-1:0]   r_ch;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_beat;
    logic                r_last;
    logic                r_err;

    generate
        for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
            assign w_push[i]     = bus.cmd_valid[i] & ~w_full[i];
            assign w_pop[i]      = w_grant_ok & bus.gnt[i];
            assign w_nonempty[i] = (w_count[i] != '0);

            cif_cmd_fifo #(
                .DEPTH (FIFO_DEPTH),
                .PTR_W (c_ptr_w),
                .WIDTH (c_data_w)
            ) u_fifo (
                .clk     (user_clk),
                .rst_n   (reset_n),
                .i_push  (w_push[i]),
                .i_data  ({bus.cmd_addr[i*ADDR_W +: ADDR_W], bus.cmd_len[i*LEN_W +: LEN_W]}),
                .i_pop   (w_pop[i]),
                .o_data  (w_dout[i]),
                .o_full  (w_full[i]),
                .o_empty (w_empty[i]),
                .o_count (w_count[i])
            );
        end
    endgenerate

    // Only a one-hot grant in IDLE on a non-empty channel pops; anything else flags err
    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (bus.gnt[i]) w_gnt_idx = c_ch_w'(i);
        end
        w_grant_ok = (r_state == IDLE) && $onehot(bus.gnt) && !w_empty[w_gnt_idx];
        w_gnt_bad  = (|bus.gnt) && !w_grant_ok;
        w_head     = w_dout[w_gnt_idx];
        w_hs       = (r_state == BURST) && bus.tx_ready;
    end

    always_comb begin
        w_done = '0;
        if (w_hs && r_last && reset_n) w_done[r_ch] = 1'b1;
    end

    always_ff @(posedge user_clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_gnt_bad) r_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_grant_ok) begin
                        r_state <= BURST;
                        r_ch    <= w_gnt_idx;
                        r_addr  <= w_head[c_data_w-1 -: ADDR_W];
                        r_len   <= w_head[LEN_W-1:0];
                        r_beat  <= '0;
                        r_last  <= (w_head[LEN_W-1:0] == '0);
                    end
                end
                BURST: begin
                    if (w_hs) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_last  <= 1'b0;
                        end else begin
                            // Address and last-flag are precomputed so they hold under backpressure
                            r_beat <= r_beat + LEN_W'(1);
                            r_addr <= r_addr + ADDR_W'(BEAT_BYTES);
                            r_last <= ((r_beat + LEN_W'(1)) == r_len);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = ~w_full;
    assign bus.req       = w_nonempty;
    assign bus.arbenb    = (r_state == IDLE);
    assign bus.tx_valid  = (r_state == BURST);
    assign bus.tx_ch     = r_ch;
    assign bus.tx_addr   = r_addr;
    assign bus.tx_last   = r_last;
    assign bus.done      = w_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cif_chreq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cif_chreq
// Brief    : Directed self-checking bench for the CIF channel requester.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cif_chreq;
    import cif_chreq_pkg::*;

    logic user_clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    cif_chreq_if #(.CH_NUM(8), .LEN_W(8), .ADDR_W(32)) bus ();

    cif_chreq #(
        .CH_NUM     (8),
        .FIFO_DEPTH (4),
        .LEN_W      (8),
        .ADDR_W     (32),
        .BEAT_BYTES (64)
    ) dut (
        .user_clk (user_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic set_cmd(input int ch, input cmd_t c);
        bus.cmd_valid[ch]        = 1'b1;
        bus.cmd_len[ch*8 +: 8]   = c.len;
        bus.cmd_addr[ch*32 +: 32] = c.addr;
    endtask

    task automatic push(input int ch, input cmd_t c);
        set_cmd(ch, c);
        tick();
        bus.cmd_valid = '0;
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.cmd_valid = '0;
        bus.gnt       = '0;
        bus.tx_ready  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.cmd_valid = '0;
        bus.cmd_len   = '0;
        bus.cmd_addr  = '0;
        bus.gnt       = '0;
        bus.tx_ready  = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.req, bus.tx_valid, bus.tx_last, bus.done, bus.err, bus.tx_ch} !== 22'h0)
            $display("FAIL reset_zero: req=%h valid=%b last=%b done=%h err=%b ch=%0d required all 0",
                     bus.req, bus.tx_valid, bus.tx_last, bus.done, bus.err, bus.tx_ch);
        else n_pass++;
        n_checks++;
        if (bus.tx_addr !== 32'h0) $display("FAIL reset_addr: got %h required 0", bus.tx_addr);
        else n_pass++;
        n_checks++;
        if (bus.cmd_ready !== 8'hFF || bus.arbenb !== 1'b1)
            $display("FAIL reset_ready_arbenb: ready=%h arbenb=%b required ff/1", bus.cmd_ready, bus.arbenb);
        else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] ea;
        bus.tx_ready = 1'b1;
        push(3, '{addr: 32'h1000, len: 8'd2});
        n_checks++;
        if (bus.req !== 8'h08 || bus.tx_valid !== 1'b0)
            $display("FAIL single_req: req=%h valid=%b required 08/0", bus.req, bus.tx_valid);
        else n_pass++;
        tick();
        bus.gnt = 8'h08;
        tick();
        bus.gnt = '0;
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.arbenb !== 1'b0 || bus.tx_ch !== 3'd3 || bus.req !== 8'h00)
            $display("FAIL single_start: valid=%b arbenb=%b ch=%0d req=%h required 1/0/3/00",
                     bus.tx_valid, bus.arbenb, bus.tx_ch, bus.req);
        else n_pass++;
        for (int b = 0; b < 3; b++) begin
            ea = 32'h1000 + 32'(b * 64);
            n_checks++;
            if (bus.tx_addr !== ea || bus.tx_last !== (b == 2) || bus.arbenb !== 1'b0 ||
                bus.done !== ((b == 2) ? 8'h08 : 8'h00))
                $display("FAIL single_beat%0d: addr=%h last=%b arbenb=%b done=%h required %h/%b/0/%h",
                         b, bus.tx_addr, bus.tx_last, bus.arbenb, bus.done, ea, (b == 2),
                         (b == 2) ? 8'h08 : 8'h00);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.arbenb !== 1'b1 || bus.done !== 8'h00)
            $display("FAIL single_end: valid=%b arbenb=%b done=%h required 0/1/00",
                     bus.tx_valid, bus.arbenb, bus.done);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int          hs;
        int          ndone;
        logic        rdy;
        logic [31:0] ea;
        hs    = 0;
        ndone = 0;
        bus.tx_ready = 1'b0;
        push(0, '{addr: 32'h2000, len: 8'd3});
        bus.gnt = 8'h01;
        tick();
        bus.gnt = '0;
        for (int k = 0; k < 40 && hs < 4; k++) begin
            rdy = ((k % 3) == 0);
            bus.tx_ready = rdy;
            #1;
            ea = 32'h2000 + 32'(hs * 64);
            n_checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_addr !== ea || bus.tx_last !== (hs == 3))
                $display("FAIL bp_cycle%0d: valid=%b addr=%h last=%b required 1/%h/%b",
                         k, bus.tx_valid, bus.tx_addr, bus.tx_last, ea, (hs == 3));
            else n_pass++;
            if (bus.done !== 8'h00) ndone++;
            if (rdy) hs++;
            tick();
        end
        n_checks++;
        if (ndone !== 1 || hs !== 4)
            $display("FAIL bp_done_count: done pulses=%0d handshakes=%0d required 1/4", ndone, hs);
        else n_pass++;
        n_checks++;
        if (bus.tx_valid !== 1'b0) $display("FAIL bp_end: valid=%b required 0", bus.tx_valid);
        else n_pass++;
    endtask

    task automatic test_full_fifo();
        do_reset();
        bus.tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_cmd(1, '{addr: 32'(k * 32'h100), len: 8'd0});
            tick();
        end
        n_checks++;
        if (bus.cmd_ready[1] !== 1'b0 || bus.req !== 8'h02)
            $display("FAIL full_ready: ready=%h req=%h required ready[1]=0 req=02", bus.cmd_ready, bus.req);
        else n_pass++;
        set_cmd(1, '{addr: 32'h400, len: 8'd0});
        tick();
        n_checks++;
        if (bus.cmd_ready !== 8'hFD) $display("FAIL full_hold: ready=%h required fd", bus.cmd_ready);
        else n_pass++;
        bus.gnt = 8'h02;
        tick();
        bus.gnt = '0;
        #1;
        n_checks++;
        if (bus.cmd_ready[1] !== 1'b1 || bus.tx_valid !== 1'b1 || bus.tx_addr !== 32'h0 ||
            bus.done !== 8'h02)
            $display("FAIL full_pop: ready1=%b valid=%b addr=%h done=%h required 1/1/0/02",
                     bus.cmd_ready[1], bus.tx_valid, bus.tx_addr, bus.done);
        else n_pass++;
        tick();
        bus.cmd_valid = '0;
        #1;
        n_checks++;
        if (bus.cmd_ready[1] !== 1'b0 || bus.tx_valid !== 1'b0 || bus.arbenb !== 1'b1)
            $display("FAIL full_refill: ready1=%b valid=%b arbenb=%b required 0/0/1",
                     bus.cmd_ready[1], bus.tx_valid, bus.arbenb);
        else n_pass++;
        bus.gnt = 8'h02;
        tick();
        bus.gnt = '0;
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_addr !== 32'h100)
            $display("FAIL full_order: valid=%b addr=%h required 1/00000100", bus.tx_valid, bus.tx_addr);
        else n_pass++;
        tick();
    endtask

    task automatic test_illegal_gnt();
        // multi-hot grant in IDLE
        do_reset();
        push(2, '{addr: 32'h3000, len: 8'd1});
        n_checks++;
        if (bus.err !== 1'b0) $display("FAIL ill_pre: err=%b required 0", bus.err);
        else n_pass++;
        bus.gnt = 8'h05;
        tick();
        bus.gnt = '0;
        #1;
        n_checks++;
        if (bus.err !== 1'b1 || bus.tx_valid !== 1'b0 || bus.req !== 8'h04)
            $display("FAIL ill_multihot: err=%b valid=%b req=%h required 1/0/04", bus.err, bus.tx_valid, bus.req);
        else n_pass++;
        // grant on an empty channel
        do_reset();
        bus.gnt = 8'h40;
        tick();
        bus.gnt = '0;
        #1;
        n_checks++;
        if (bus.err !== 1'b1 || bus.tx_valid !== 1'b0 || bus.arbenb !== 1'b1 || bus.cmd_ready !== 8'hFF)
            $display("FAIL ill_empty: err=%b valid=%b arbenb=%b ready=%h required 1/0/1/ff",
                     bus.err, bus.tx_valid, bus.arbenb, bus.cmd_ready);
        else n_pass++;
        // grant while a burst is in flight
        do_reset();
        set_cmd(0, '{addr: 32'h4000, len: 8'd0});
        set_cmd(2, '{addr: 32'h3000, len: 8'd1});
        tick();
        bus.cmd_valid = '0;
        bus.gnt = 8'h04;
        tick();
        bus.gnt = '0;
        #1;
        n_checks++;
        if (bus.err !== 1'b0 || bus.tx_valid !== 1'b1 || bus.tx_ch !== 3'd2)
            $display("FAIL ill_legal: err=%b valid=%b ch=%0d required 0/1/2", bus.err, bus.tx_valid, bus.tx_ch);
        else n_pass++;
        bus.gnt = 8'h01;
        tick();
        bus.gnt = '0;
        #1;
        n_checks++;
        if (bus.err !== 1'b1 || bus.tx_ch !== 3'd2 || bus.tx_addr !== 32'h3000 || bus.req !== 8'h01)
            $display("FAIL ill_inburst: err=%b ch=%0d addr=%h req=%h required 1/2/00003000/01",
                     bus.err, bus.tx_ch, bus.tx_addr, bus.req);
        else n_pass++;
        bus.tx_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.tx_addr !== 32'h3000 || bus.tx_last !== 1'b0 || bus.done !== 8'h00)
            $display("FAIL ill_beat0: addr=%h last=%b done=%h required 00003000/0/00",
                     bus.tx_addr, bus.tx_last, bus.done);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.tx_addr !== 32'h3040 || bus.tx_last !== 1'b1 || bus.done !== 8'h04)
            $display("FAIL ill_beat1: addr=%h last=%b done=%h required 00003040/1/04",
                     bus.tx_addr, bus.tx_last, bus.done);
        else n_pass++;
        tick();
        bus.gnt = 8'h01;
        tick();
        bus.gnt = '0;
        #1;
        n_checks++;
        if (bus.err !== 1'b1 || bus.tx_ch !== 3'd0 || bus.tx_addr !== 32'h4000)
            $display("FAIL ill_sticky: err=%b ch=%0d addr=%h required 1/0/00004000",
                     bus.err, bus.tx_ch, bus.tx_addr);
        else n_pass++;
        tick();
    endtask

    task automatic test_wrap_maxlen();
        logic [31:0] ea;
        logic [7:0]  ed;
        do_reset();
        bus.tx_ready = 1'b1;
        push(5, '{addr: 32'hFFFF_FFC0, len: 8'd255});
        bus.gnt = 8'h20;
        tick();
        bus.gnt = '0;
        #1;
        for (int b = 0; b < 256; b++) begin
            ea = 32'hFFFF_FFC0 + 32'(b * 64);
            ed = (b == 255) ? 8'h20 : 8'h00;
            n_checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_addr !== ea || bus.tx_last !== (b == 255) || bus.done !== ed)
                $display("FAIL wrap_beat%0d: valid=%b addr=%h last=%b done=%h required 1/%h/%b/%h",
                         b, bus.tx_valid, bus.tx_addr, bus.tx_last, bus.done, ea, (b == 255), ed);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.arbenb !== 1'b1)
            $display("FAIL wrap_end: valid=%b arbenb=%b required 0/1", bus.tx_valid, bus.arbenb);
        else n_pass++;
    endtask

    task automatic test_reset_midburst();
        do_reset();
        set_cmd(4, '{addr: 32'h5000, len: 8'd4});
        set_cmd(7, '{addr: 32'h7000, len: 8'd0});
        tick();
        bus.cmd_valid = '0;
        bus.gnt = 8'h10;
        tick();
        bus.gnt = '0;
        bus.tx_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.tx_addr !== 32'h5080 || bus.tx_valid !== 1'b1)
            $display("FAIL rst_beat2: addr=%h valid=%b required 00005080/1", bus.tx_addr, bus.tx_valid);
        else n_pass++;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.arbenb !== 1'b1 || bus.req !== 8'h00 || bus.done !== 8'h00 ||
            bus.tx_addr !== 32'h0 || bus.tx_ch !== 3'd0 || bus.tx_last !== 1'b0 || bus.cmd_ready !== 8'hFF)
            $display("FAIL rst_mid: valid=%b arbenb=%b req=%h done=%h addr=%h ch=%0d last=%b ready=%h required reset values",
                     bus.tx_valid, bus.arbenb, bus.req, bus.done, bus.tx_addr, bus.tx_ch, bus.tx_last, bus.cmd_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.req !== 8'h00 || bus.tx_valid !== 1'b0 || bus.done !== 8'h00)
            $display("FAIL rst_after: req=%h valid=%b done=%h required 00/0/00", bus.req, bus.tx_valid, bus.done);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_full_fifo();
        test_illegal_gnt();
        test_wrap_maxlen();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cif_chreq.md
Name: cif_chreq

Overview:
- Requester side of the CIF channel arbitration handshake.
- Holds up to FIFO_DEPTH transfer commands per channel and drives one req bit per channel into the round-robin arbiter.
- On a one-hot gnt pulse, pops the granted channel's head command and plays it out as a burst of beats on a single shared transmit bus.
- Drives arbenb low while a burst is in flight, so only one burst owns the bus at a time.

Parameters:
CH_NUM, 8, number of channels; req/gnt width.
FIFO_DEPTH, 4, command entries per channel; power of 2, at least 2.
LEN_W, 8, burst length field width; a value of N means N+1 beats.
ADDR_W, 32, address width.
BEAT_BYTES, 64, address increment per beat.

Ports:
- user_clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  CH_NUM  per-channel command valid.
- cmd_ready  out  CH_NUM  per-channel command ready; asserted when that channel's count < FIFO_DEPTH.
- cmd_len  in  CH_NUM*LEN_W  per-channel length field; channel i occupies slice [i*LEN_W +: LEN_W].
- cmd_addr  in  CH_NUM*ADDR_W  per-channel base address; sliced the same way as cmd_len.
- req  out  CH_NUM  to the arbiter.
- gnt  in  CH_NUM  from the arbiter; one-hot, single-cycle pulse.
- arbenb  out  1  arbitration enable to the arbiter.
- tx_valid  out  1  beat valid.
- tx_ready  in  1  beat accept.
- tx_ch  out  $clog2(CH_NUM)  channel owning the current burst.
- tx_addr  out  ADDR_W  address of the current beat.
- tx_last  out  1  final beat of the burst.
- done  out  CH_NUM  one-cycle pulse on the channel whose last beat handshakes.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset, sampled on the user_clk edge while reset_n=0:
  - All FIFOs empty.
  - State IDLE.
  - Outputs: req=0, tx_valid=0, tx_last=0, done=0, err=0, tx_ch=0, tx_addr=0.
  - cmd_ready=all-ones; arbenb=1.
- Reset asserted mid-burst: the burst is abandoned, all queued commands are discarded, and no done pulse is issued.
- Command push:
  - Channel i pushes when cmd_valid[i] & cmd_ready[i].
  - Push is registered; req[i] rises the next cycle.
  - req[i] = FIFO i non-empty, registered.
- Full FIFO: cmd_ready[i] is low while count = FIFO_DEPTH, even if a pop happens in the same cycle (no bypass). A pop and push on the same non-full channel in one cycle leaves the count unchanged.
- State machine, states IDLE and BURST:
  - IDLE: arbenb=1, tx_valid=0.
  - IDLE, on gnt one-hot at bit g with FIFO g non-empty:
    - Pop the head of FIFO g.
    - Latch tx_ch=g, base address, beat counter=0, remaining=len.
    - Go to BURST.
    - req[g] is recomputed from the post-pop count the next cycle.
  - BURST: arbenb=0, tx_valid=1.
  - tx_addr = base + beat*BEAT_BYTES, modulo 2^ADDR_W (wraps silently).
  - tx_last = (beat == len).
  - Beat advance: on each tx_valid & tx_ready, beat increments; tx_addr and tx_last must be stable while tx_ready=0.
  - Last beat handshake: done[tx_ch] pulses in the same cycle, and the state returns to IDLE the next cycle.
  - arbenb is back to 1 the cycle after the last handshake, so a new grant can arrive no earlier than 2 cycles after the last handshake.
- Latency, with an idle bus: push at T -> req at T+1 -> gnt at T+2 (arbiter latency) -> tx_valid at T+3.
- Error cases (err set; it is cleared only by reset):
  - gnt with more than one bit set: ignored.
  - gnt while in BURST: ignored.
  - gnt on an empty channel: ignored, no pop.
- Length: len=0 is a single-beat burst with tx_last=1 on its only beat. len = 2^LEN_W-1 gives 2^LEN_W beats; the beat counter is LEN_W bits and must not overflow before tx_last.

Decomposition:
- Package cif_chreq_pkg:
  - typedef cmd_t {addr, len}.
  - localparams CH_W=$clog2(CH_NUM) and PTR_W=$clog2(FIFO_DEPTH).
  - State enum {IDLE, BURST}.
- Sub-module cif_cmd_fifo: single-clock FIFO, synchronous active-low reset, DEPTH/PTR_W parameters, push/pop/full/empty/count. Instantiated CH_NUM times in a generate loop.
- The top level holds the state machine, burst registers and error logic.

Test Plan:
1. Single command: ch3 len=2 addr=0x1000, tx_ready=1, gnt pulsed at bit3 two cycles after push -> three beats at 0x1000, 0x1040, 0x1080; tx_last on the third; done[3] pulses; arbenb=0 throughout the burst.
2. Backpressure: ch0 len=3, tx_ready toggling 1,0,0,1,... -> exactly 4 handshakes; tx_addr and tx_last hold while ready=0; one done[0] pulse.
3. Full FIFO: push 5 commands on ch1 with FIFO_DEPTH=4 and no gnt -> cmd_ready[1] low after the 4th push; the 5th is held off. Then gnt ch1 -> the pop restores cmd_ready[1]=1 the next cycle.
4. Illegal grants: gnt=8'h05 in IDLE, then gnt=8'h01 during a burst, then gnt on an empty ch6 -> err=1 and sticky; no pop, no state change; the current burst completes normally.
5. Wrap and max length: addr=0xFFFFFFC0, len=255 -> 256 beats; the second beat has address 0x00000000; tx_last only on beat 255.
6. Reset mid-burst: reset_n=0 for 1 cycle at beat 2 of 5 -> next cycle all outputs at reset values, FIFOs empty, no done pulse, arbenb=1.
